// File: rtl/dbg_pkg.sv
// Shared encodings for the debug run-control unit and its register dump sequencer.
package dbg_pkg;

  // Register file geometry seen through the core's debug read port
  localparam int unsigned NRegs = 32;
  localparam int unsigned IdxW  = $clog2(NRegs);

  // Host command opcodes carried on cmd_op
  typedef enum logic [2:0] {
    OpNop   = 3'd0,
    OpRun   = 3'd1,
    OpHalt  = 3'd2,
    OpStep  = 3'd3,
    OpSetBp = 3'd4,
    OpClrBp = 3'd5,
    OpDump  = 3'd6,
    OpRsvd  = 3'd7
  } dbg_op_e;

  // Run-control states; StDump covers both dump phases owned by reg_dump_seq
  typedef enum logic [1:0] {
    StHalted,
    StRun,
    StStep,
    StDump
  } run_state_e;

  // Dump sequencer phases
  typedef enum logic [1:0] {
    StDumpIdle,
    StDumpRd,
    StDumpOut
  } dump_state_e;

  // Ops that change the core's execution flow and are only legal while halted
  function automatic logic op_needs_halt(dbg_op_e op);
    return op inside {OpRun, OpStep, OpDump};
  endfunction

endpackage

// File: rtl/reg_dump_seq.sv
// Walks the core register file through the debug read port, one beat per register,
// presenting each value on a valid/ready handshake to the host.
module reg_dump_seq
  import dbg_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  output logic [IdxW-1:0] ra_debug_o,
  input  logic [31:0]     ra_debug_data_i,
  output logic            dump_valid_o,
  input  logic            dump_ready_i,
  output logic [IdxW-1:0] dump_idx_o,
  output logic [31:0]     dump_data_o,
  output logic            done_o
);

  dump_state_e     state_q;
  logic [IdxW-1:0] idx_q;
  logic            dump_valid_q;
  logic [IdxW-1:0] dump_idx_q;
  logic [31:0]     dump_data_q;
  logic            last_idx;

  // Read port address and the completion pulse for the final accepted beat
  always_comb begin
    last_idx   = (idx_q == IdxW'(NRegs - 1));
    ra_debug_o = (state_q == StDumpIdle) ? '0 : idx_q;
    done_o     = (state_q == StDumpOut) && dump_ready_i && last_idx;
  end

  // Dump FSM: read one register, hold it until the host takes it, move on
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StDumpIdle;
      idx_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
    end else begin
      case (state_q)
        StDumpIdle: begin
          if (start_i) begin
            state_q <= StDumpRd;
            idx_q   <= '0;
          end
        end
        StDumpRd: begin
          dump_data_q  <= ra_debug_data_i;
          dump_idx_q   <= idx_q;
          dump_valid_q <= 1'b1;
          state_q      <= StDumpOut;
        end
        StDumpOut: begin
          // Beat stays frozen until the host accepts it
          if (dump_ready_i) begin
            dump_valid_q <= 1'b0;
            if (last_idx) begin
              state_q <= StDumpIdle;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              state_q <= StDumpRd;
            end
          end
        end
        default: state_q <= StDumpIdle;
      endcase
    end
  end

  assign dump_valid_o = dump_valid_q;
  assign dump_idx_o   = dump_idx_q;
  assign dump_data_o  = dump_data_q;

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run control for the single-cycle core: halt, run, N-step, PC breakpoint and
// register dump, driven from a host command interface.
module dbg_run_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned StepW = 16,
  parameter int unsigned CycW  = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [2:0]      cmd_op_i,
  input  logic [31:0]     cmd_arg_i,
  output logic            cmd_err_o,
  input  logic [31:0]     pc_i,
  output logic            cpu_en_o,
  output logic [IdxW-1:0] ra_debug_o,
  input  logic [31:0]     ra_debug_data_i,
  output logic            dump_valid_o,
  input  logic            dump_ready_i,
  output logic [IdxW-1:0] dump_idx_o,
  output logic [31:0]     dump_data_o,
  output logic            halted_o,
  output logic            bp_hit_o,
  output logic [CycW-1:0] retired_o
);

  run_state_e       state_q;
  logic [StepW-1:0] step_cnt_q;
  logic             bp_en_q;
  logic [31:0]      bp_addr_q;
  logic             skip_bp_q;
  logic             bp_hit_q;
  logic             halted_q;
  logic             cmd_err_q;
  logic [CycW-1:0]  retired_q;

  dbg_op_e          op;
  logic             cmd_acc;
  logic             cmd_rej;
  logic             is_halt;
  logic             bp_match;
  logic             cpu_en;
  logic             dump_start;
  logic             dump_done;
  logic [StepW-1:0] step_arg;

  // Command decode, breakpoint compare and core clock enable
  always_comb begin
    op          = dbg_op_e'(cmd_op_i);
    cmd_ready_o = (state_q != StDump);
    cmd_acc     = cmd_valid_i && cmd_ready_o;
    is_halt     = cmd_acc && (op == OpHalt);
    // skip_bp lets a resumed run execute the instruction it stopped on
    bp_match    = bp_en_q && (pc_i == bp_addr_q) && !skip_bp_q;
    case (state_q)
      StRun:   cpu_en = !bp_match;
      StStep:  cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
    dump_start  = cmd_acc && (state_q == StHalted) && (op == OpDump);
    step_arg    = (cmd_arg_i[StepW-1:0] == '0) ? StepW'(1) : cmd_arg_i[StepW-1:0];
    // Reserved op is always rejected; flow ops only while halted
    cmd_rej     = cmd_acc && ((op == OpRsvd) || ((state_q != StHalted) && op_needs_halt(op)));
  end

  // Run-control FSM with breakpoint registers, error pulse and retire counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StHalted;
      halted_q   <= 1'b1;
      step_cnt_q <= '0;
      bp_en_q    <= 1'b0;
      bp_addr_q  <= '0;
      skip_bp_q  <= 1'b0;
      bp_hit_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      cmd_err_q <= cmd_rej;

      if (cpu_en) begin
        retired_q <= retired_q + CycW'(1);
        skip_bp_q <= 1'b0;
      end

      if (cmd_acc && (op == OpSetBp)) begin
        bp_en_q   <= 1'b1;
        bp_addr_q <= cmd_arg_i;
      end else if (cmd_acc && (op == OpClrBp)) begin
        bp_en_q <= 1'b0;
      end

      case (state_q)
        StHalted: begin
          if (cmd_acc) begin
            case (op)
              OpRun: begin
                state_q   <= StRun;
                halted_q  <= 1'b0;
                skip_bp_q <= 1'b1;
                bp_hit_q  <= 1'b0;
              end
              OpStep: begin
                state_q    <= StStep;
                halted_q   <= 1'b0;
                step_cnt_q <= step_arg;
                bp_hit_q   <= 1'b0;
              end
              OpDump: begin
                state_q  <= StDump;
                halted_q <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        StRun: begin
          // Breakpoint wins over a same-cycle HALT so bp_hit is still reported
          if (bp_match) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
            bp_hit_q <= 1'b1;
          end else if (is_halt) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end
        end
        StStep: begin
          step_cnt_q <= step_cnt_q - StepW'(1);
          if ((step_cnt_q == StepW'(1)) || is_halt) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end
        end
        StDump: begin
          if (dump_done) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StHalted;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  reg_dump_seq u_dump (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (dump_start),
    .ra_debug_o      (ra_debug_o),
    .ra_debug_data_i (ra_debug_data_i),
    .dump_valid_o    (dump_valid_o),
    .dump_ready_i    (dump_ready_i),
    .dump_idx_o      (dump_idx_o),
    .dump_data_o     (dump_data_o),
    .done_o          (dump_done)
  );

  assign cpu_en_o  = cpu_en;
  assign cmd_err_o = cmd_err_q;
  assign halted_o  = halted_q;
  assign bp_hit_o  = bp_hit_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Bench for dbg_run_ctrl: a toy core (PC + register file) around the DUT, a behavioural
// model checked every cycle, and literal spot checks at key points.
module tb_dbg_run_ctrl;

  localparam logic [2:0] C_RUN  = 3'd1;
  localparam logic [2:0] C_HALT = 3'd2;
  localparam logic [2:0] C_STEP = 3'd3;
  localparam logic [2:0] C_SBP  = 3'd4;
  localparam logic [2:0] C_CBP  = 3'd5;
  localparam logic [2:0] C_DUMP = 3'd6;
  localparam logic [2:0] C_BAD  = 3'd7;

  localparam int MHalt = 0;
  localparam int MRun  = 1;
  localparam int MStep = 2;
  localparam int MDump = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        cmd_err;
  logic [31:0] pc;
  logic        cpu_en;
  logic [4:0]  ra_debug;
  logic [31:0] ra_debug_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        halted;
  logic        bp_hit;
  logic [31:0] retired;

  logic [31:0] regs [32];
  logic        pc_set = 1'b0;
  logic [31:0] pc_set_val = 32'd0;
  bit          tog_en = 1'b0;
  bit          ready_hold = 1'b0;
  bit          check_en = 1'b0;
  int          beats = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Behavioural model state
  int          m_mode;
  int          m_left;
  int          m_beat;
  bit          m_present;
  bit          m_skip;
  bit          m_bp_en;
  bit          m_bp_hit;
  bit          m_err;
  logic [31:0] m_bp_addr;
  logic [31:0] m_retired;

  always #5 clk = ~clk;

  dbg_run_ctrl #(
    .StepW (16),
    .CycW  (32)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_op_i        (cmd_op),
    .cmd_arg_i       (cmd_arg),
    .cmd_err_o       (cmd_err),
    .pc_i            (pc),
    .cpu_en_o        (cpu_en),
    .ra_debug_o      (ra_debug),
    .ra_debug_data_i (ra_debug_data),
    .dump_valid_o    (dump_valid),
    .dump_ready_i    (dump_ready),
    .dump_idx_o      (dump_idx),
    .dump_data_o     (dump_data),
    .halted_o        (halted),
    .bp_hit_o        (bp_hit),
    .retired_o       (retired)
  );

  // Toy core: PC advances by 4 per enabled cycle, register file read combinationally
  assign ra_debug_data = regs[ra_debug];

  always @(posedge clk) begin
    if (pc_set) pc <= pc_set_val;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  always @(posedge clk) begin
    if (rst_n && dump_valid && dump_ready) beats <= beats + 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    dump_ready = tog_en ? ~dump_ready : ready_hold;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic bit m_cpu_en();
    if (m_mode == MRun) return !(m_bp_en && (pc == m_bp_addr) && !m_skip);
    if (m_mode == MStep) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = MHalt; m_left = 0; m_beat = 0; m_present = 0; m_skip = 0;
    m_bp_en = 0; m_bp_hit = 0; m_err = 0; m_bp_addr = 0; m_retired = 0;
  endtask

  task automatic model_edge();
    bit en;
    bit acc;
    bit halt_cmd;
    en = m_cpu_en();
    acc = cmd_valid && (m_mode != MDump);
    halt_cmd = acc && (cmd_op == C_HALT);
    m_err = acc && ((cmd_op == C_BAD) ||
            ((m_mode != MHalt) && (cmd_op == C_RUN || cmd_op == C_STEP || cmd_op == C_DUMP)));
    if (en) begin
      m_retired = m_retired + 32'd1;
      m_skip = 0;
    end
    case (m_mode)
      MHalt: if (acc) begin
        if (cmd_op == C_RUN) begin m_mode = MRun; m_skip = 1; m_bp_hit = 0; end
        else if (cmd_op == C_STEP) begin
          m_mode = MStep; m_bp_hit = 0;
          m_left = (cmd_arg[15:0] == 16'd0) ? 1 : int'(cmd_arg[15:0]);
        end else if (cmd_op == C_DUMP) begin m_mode = MDump; m_beat = 0; m_present = 0; end
      end
      MRun: begin
        if (!en) begin m_mode = MHalt; m_bp_hit = 1; end
        else if (halt_cmd) m_mode = MHalt;
      end
      MStep: begin
        m_left--;
        if (m_left == 0 || halt_cmd) m_mode = MHalt;
      end
      default: begin
        if (!m_present) m_present = 1;
        else if (dump_ready) begin
          if (m_beat == 31) m_mode = MHalt;
          else begin m_beat++; m_present = 0; end
        end
      end
    endcase
    if (acc && cmd_op == C_SBP) begin m_bp_en = 1; m_bp_addr = cmd_arg; end
    if (acc && cmd_op == C_CBP) m_bp_en = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_edge();
  end

  // Per-cycle comparison against the model, mid-cycle
  initial forever begin
    @(negedge clk);
    if (rst_n && check_en) begin
      check("cpu_en", cpu_en, m_cpu_en());
      check("halted", halted, m_mode == MHalt);
      check("bp_hit", bp_hit, m_bp_hit);
      check("retired", retired, m_retired);
      check("cmd_ready", cmd_ready, m_mode != MDump);
      check("cmd_err", cmd_err, m_err);
      check("dump_valid", dump_valid, (m_mode == MDump) && m_present);
      if (m_mode != MDump) check("ra_debug_idle", ra_debug, 0);
      else if (!m_present) check("ra_debug_rd", ra_debug, m_beat);
      if ((m_mode == MDump) && m_present) begin
        check("dump_idx", dump_idx, m_beat);
        check("dump_data", dump_data, 32'h100 + m_beat);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 32'd0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_set = 1'b1; pc_set_val = v;
    @(posedge clk);
    #1;
    pc_set = 1'b0;
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, halted, 1);
  endtask

  initial begin
    int b0;
    int n;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    pc_set = 1'b1; pc_set_val = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pc_set = 1'b0;
    check("rst_halted", halted, 1);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_retired", retired, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check_en = 1;

    // N-step and zero-step
    send(C_STEP, 32'd3);
    wait_halted("step3_done", 20);
    check("step3_retired", retired, 3);
    check("step3_pc", pc, 32'hC);
    send(C_STEP, 32'd0);
    wait_halted("step0_done", 20);
    check("step0_retired", retired, 4);

    // Reserved opcode
    send(C_BAD, 32'd0);
    check("err_op7", cmd_err, 1);

    // Breakpoint at 0x10, then resume past it and halt by command
    set_pc(32'd0);
    send(C_SBP, 32'h10);
    send(C_RUN, 32'd0);
    wait_halted("bp_done", 40);
    check("bp_pc", pc, 32'h10);
    check("bp_hit_set", bp_hit, 1);
    check("bp_retired", retired, 8);
    send(C_RUN, 32'd0);
    tick(3);
    send(C_HALT, 32'd0);
    check("halt_immediate", halted, 1);
    check("halt_pc", pc, 32'h20);
    check("halt_retired", retired, 12);
    check("halt_bp_clear", bp_hit, 0);

    // Full dump with a toggling ready
    send(C_CBP, 32'd0);
    b0 = beats;
    tog_en = 1;
    send(C_DUMP, 32'd0);
    wait_halted("dump_done", 200);
    tog_en = 0;
    check("dump_beats", beats - b0, 32);
    check("dump_retired", retired, 12);

    // Dump while running is rejected, run continues
    set_pc(32'd0);
    send(C_RUN, 32'd0);
    tick(2);
    send(C_DUMP, 32'd0);
    check("dump_in_run_err", cmd_err, 1);
    tick(3);
    check("dump_in_run_running", halted, 0);
    check("dump_in_run_novalid", dump_valid, 0);
    send(C_HALT, 32'd0);
    tick(1);

    // Asynchronous reset in the middle of a dump
    send(C_SBP, 32'h10);
    ready_hold = 1;
    send(C_DUMP, 32'd0);
    n = 0;
    while (!(dump_valid && dump_idx == 5'd7) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_idx7", dump_idx, 7);
    #2;
    rst_n = 1'b0;
    ready_hold = 0;
    #1;
    check("arst_halted", halted, 1);
    check("arst_dump_valid", dump_valid, 0);
    check("arst_cpu_en", cpu_en, 0);
    check("arst_retired", retired, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_pc(32'd0);
    send(C_RUN, 32'd0);
    tick(6);
    check("nobp_running", halted, 0);
    check("nobp_bp_hit", bp_hit, 0);
    check("nobp_pc_past", pc > 32'h10, 1);
    send(C_HALT, 32'd0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
